dff_edge_detect_bank: RTL and testbench
=======================================

Name: dff_edge_detect_bank

Overview:
- Parametrised multi-channel successor to the single edge-triggered D flip-flop.
- Each channel passes an asynchronous input through a configurable synchroniser chain of rising-edge flops.
- Each channel detects rising, falling or both transitions according to a mode input, emits a one-cycle edge pulse, and keeps a saturating per-channel edge counter.
- Sits between raw external inputs and control logic as the standard input-conditioning stage.

Parameters:
- CH, 4: number of independent channels.
- SYNC_STAGES, 2: flops per channel synchroniser chain including the output flop; legal range 2..4.
- CNT_W, 8: width of each per-channel edge counter.

Ports:
- inClk  input  1  clock; all state updates on rising edge.
- inRstN  input  1  synchronous active-low reset, sampled on rising edge of inClk.
- inD  input  CH  raw per-channel data inputs, may be asynchronous.
- inEn  input  1  detection enable; low suppresses edge pulses and counting.
- inMode  input  2  00 none, 01 rising, 10 falling, 11 both.
- inClrCnt  input  1  synchronous clear of all counters.
- outQ  output  CH  synchronised data; the last flop of each chain.
- outEdge  output  CH  registered one-cycle edge pulse per channel.
- outCnt  output  CH*CNT_W  channel i count at bits [i*CNT_W +: CNT_W].
- outAny  output  1  combinational OR of outEdge.

Behaviour:
- Clock and reset: one clock, inClk. Reset is synchronous and active-low (inRstN). While inRstN=0 at a rising edge, all chain flops, outQ, outEdge and all counters go to 0. Hence outAny=0. No output changes asynchronously to reset.
- Chain: stage s[0] <= inD; s[k] <= s[k-1]; outQ = s[SYNC_STAGES-1].
- Latency: an inD value captured at edge k appears on outQ after edge k+SYNC_STAGES-1.
- Edge evaluation at each rising edge compares the pre-edge values of s[SYNC_STAGES-2] and outQ:
  - rise = s[SYNC_STAGES-2] & ~outQ
  - fall = ~s[SYNC_STAGES-2] & outQ
- outEdge[i] <= inEn & ((inMode[0] & rise[i]) | (inMode[1] & fall[i])).
  - outEdge rises in the same cycle outQ[i] first shows the new value.
  - It lasts exactly one cycle per transition.
- Back-to-back transitions: consecutive single-cycle toggles of the chain yield outEdge high in consecutive cycles in mode 11. Each counts separately.
- Counter per channel, priority order:
  1. reset
  2. inClrCnt=1: counter <= 0; clear wins over a simultaneous edge
  3. increment by 1 on the edge where outEdge[i] is being set to 1
  4. hold
- Saturation: the counter saturates at 2^CNT_W-1 and never wraps.
- inEn=0: the chain and outQ keep tracking. outEdge is forced to 0 from the next edge, and counters hold. Transitions occurring while disabled are lost, not deferred.
- Mode changes take effect on the first rising edge at which the new value is sampled. No pulse is generated retroactively.
- Post-reset: the chain restarts from 0. An inD already high when inRstN rises is reported as a rising edge once it propagates (mode 01/11).
- Reset mid-operation: all state cleared at that edge. Any in-flight pulse or pending chain value is discarded.
- Input pulses shorter than one inClk period may be missed; no capture guarantee.
- Channels are fully independent; simultaneous edges on all channels are all reported in the same cycle.

Test Plan:
- Reset release: clock period 40 ns, inRstN=0 for 2 edges with inD=4'hF, then release (mode 01, inEn=1) -> all outputs 0 during reset; outQ=4'hF and outEdge=4'hF for exactly 1 cycle after 2nd post-release edge; each count=1; outAny pulses once.
- Falling mode: inMode=10, inD[0] toggles 0->1->0 with 5 cycles per level -> outEdge[0] pulses only on 1->0; cnt[0]=1; other channels 0.
- Saturation: inMode=11, inD[1] toggles every edge for 300 cycles -> outEdge[1] high continuously after latency; cnt[1] reaches 255 and holds 255.
- Clear priority: inClrCnt=1 in the same cycle outEdge[2] is being set, cnt[2]=7 beforehand -> cnt[2]=0 next cycle, not 1; cnt[2]=1 on the following edge pulse.
- Enable gating: inEn=0, inD[3] toggles 4 times -> outQ[3] follows with 2-edge latency; outEdge[3]=0; cnt[3] unchanged. Set inEn=1 and toggle once -> cnt[3] increments by 1.
- Mode 00 and mid-run reset: inMode=00 with activity -> no pulses. Assert inRstN=0 for one edge with nonzero counts -> all outputs 0 after that edge.

Source files
------------

// File: rtl/dff_edge_detect_bank.sv
// Multi-channel input conditioner: synchroniser chain, edge detect, saturating edge counters.
// Latency: inD -> outQ in SYNC_STAGES-1 edges after capture; outEdge rises with the new outQ.
// Backpressure: none; every channel is evaluated every cycle, no stall path.
//
// Ports:
//   inClk    - clock, all state updates on the rising edge
//   inRstN   - synchronous active-low reset
//   inD      - raw (possibly asynchronous) per-channel inputs
//   inEn     - detection enable; low suppresses pulses and counting
//   inMode   - 00 none, 01 rising, 10 falling, 11 both
//   inClrCnt - synchronous clear of all counters (wins over a simultaneous edge)
//   outQ     - synchronised data (last chain flop)
//   outEdge  - registered one-cycle edge pulse per channel
//   outCnt   - per-channel saturating counts, channel i at [i*CNT_W +: CNT_W]
//   outAny   - OR of outEdge
module dff_edge_detect_bank #(
  parameter int CH          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 8
) (
  input  logic                inClk,
  input  logic                inRstN,
  input  logic [CH-1:0]       inD,
  input  logic                inEn,
  input  logic [1:0]          inMode,
  input  logic                inClrCnt,
  output logic [CH-1:0]       outQ,
  output logic [CH-1:0]       outEdge,
  output logic [CH*CNT_W-1:0] outCnt,
  output logic                outAny
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // sync_q[k] is stage k of every channel's chain; stage SYNC_STAGES-1 is outQ.
  logic [SYNC_STAGES-1:0][CH-1:0] sync_q, sync_d;
  logic [CH-1:0]                  edge_q, edge_d;
  logic [CH-1:0]                  rise, fall;
  logic [CH-1:0][CNT_W-1:0]       cnt_q, cnt_d;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = inD;
    for (int k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  // Compare the value about to enter the output flop with the one it holds now,
  // so the pulse appears in the same cycle outQ shows the new level.
  assign rise = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
  assign fall = ~sync_q[SYNC_STAGES-2] & sync_q[SYNC_STAGES-1];

  always_comb begin
    edge_d = {CH{inEn}} & (({CH{inMode[0]}} & rise) | ({CH{inMode[1]}} & fall));
  end

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < CH; i++) begin
      if (inClrCnt) begin
        cnt_d[i] = '0;
      end else if (edge_d[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge inClk) begin
    if (!inRstN) begin
      sync_q <= '0;
      edge_q <= '0;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      edge_q <= edge_d;
      cnt_q  <= cnt_d;
    end
  end

  assign outQ    = sync_q[SYNC_STAGES-1];
  assign outEdge = edge_q;
  assign outCnt  = cnt_q;
  assign outAny  = |edge_q;

endmodule

// File: tb/tb_dff_edge_detect_bank.sv
module tb_dff_edge_detect_bank;
  localparam int CH = 4;
  localparam int SS = 2;
  localparam int CW = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [CH-1:0]     d;
  logic              en;
  logic [1:0]        mode;
  logic              clr;
  logic [CH-1:0]     out_q;
  logic [CH-1:0]     out_edge;
  logic [CH*CW-1:0]  out_cnt;
  logic              out_any;

  int checks   = 0;
  int failures = 0;

  dff_edge_detect_bank #(.CH(CH), .SYNC_STAGES(SS), .CNT_W(CW)) dut (
    .inClk(clk), .inRstN(rst_n), .inD(d), .inEn(en), .inMode(mode),
    .inClrCnt(clr), .outQ(out_q), .outEdge(out_edge), .outCnt(out_cnt),
    .outAny(out_any)
  );

  always #20 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: outQ is the input sample from SS-1 edges ago (zero-filled
  // after reset); a pulse is any enabled, mode-selected change of that value.
  logic [CH-1:0] pipe [$];
  logic [CH-1:0] mq, medge, new_q, rise_m, fall_m;
  int            mcnt [CH];

  always @(posedge clk) begin
    if (!rst_n) begin
      pipe.delete();
      for (int k = 0; k < SS-1; k++) pipe.push_back('0);
      mq = '0;
      medge = '0;
      for (int i = 0; i < CH; i++) mcnt[i] = 0;
    end else begin
      new_q = pipe.pop_front();
      pipe.push_back(d);
      rise_m = new_q & ~mq;
      fall_m = ~new_q & mq;
      medge = '0;
      if (en) begin
        if (mode[0]) medge = medge | rise_m;
        if (mode[1]) medge = medge | fall_m;
      end
      for (int i = 0; i < CH; i++) begin
        if (clr) mcnt[i] = 0;
        else if (medge[i] && mcnt[i] < (1 << CW) - 1) mcnt[i] = mcnt[i] + 1;
      end
      mq = new_q;
    end
  end

  always @(negedge clk) begin
    logic [CH*CW-1:0] exp_cnt;
    for (int i = 0; i < CH; i++) exp_cnt[i*CW +: CW] = mcnt[i][CW-1:0];
    check("model_q", 64'(out_q), 64'(mq));
    check("model_edge", 64'(out_edge), 64'(medge));
    check("model_cnt", 64'(out_cnt), 64'(exp_cnt));
    check("model_any", 64'(out_any), 64'(|medge));
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  function automatic logic [CW-1:0] cnt_of(input int i);
    return out_cnt[i*CW +: CW];
  endfunction

  int           ep;
  int           hi;
  logic [CW-1:0] c3;

  initial begin
    rst_n = 1'b0; d = 4'hF; en = 1'b1; mode = 2'b01; clr = 1'b0;

    // Reset release with inputs already high
    tick(1);
    check("rst_q", 64'(out_q), 64'h0);
    check("rst_edge_cnt", 64'({out_edge, out_cnt, out_any}), 64'h0);
    tick(1);
    check("rst2_all", 64'({out_q, out_edge, out_cnt, out_any}), 64'h0);
    rst_n = 1'b1;
    tick(1);
    check("rel1_q", 64'(out_q), 64'h0);
    check("rel1_edge", 64'(out_edge), 64'h0);
    tick(1);
    check("rel2_q", 64'(out_q), 64'hF);
    check("rel2_edge", 64'(out_edge), 64'hF);
    check("rel2_any", 64'(out_any), 64'h1);
    check("rel2_cnt", 64'(out_cnt), 64'h01010101);
    tick(1);
    check("rel3_edge", 64'({out_edge, out_any}), 64'h0);
    check("rel3_cnt", 64'(out_cnt), 64'h01010101);

    // Falling mode on channel 0
    d = '0;
    tick(4);
    clr = 1'b1; tick(1); clr = 1'b0;
    mode = 2'b10;
    ep = 0;
    d[0] = 1'b1;
    repeat (5) begin tick(1); ep += int'(out_edge[0]); end
    check("fall_on_rise", 64'(ep), 64'h0);
    ep = 0;
    d[0] = 1'b0;
    repeat (5) begin tick(1); ep += int'(out_edge[0]); end
    check("fall_on_fall", 64'(ep), 64'h1);
    check("fall_cnt0", 64'(cnt_of(0)), 64'h1);
    check("fall_cnt_oth", 64'(out_cnt[CH*CW-1:CW]), 64'h0);

    // Saturation on channel 1
    mode = 2'b11;
    clr = 1'b1; tick(1); clr = 1'b0;
    hi = 0;
    repeat (300) begin
      d[1] = ~d[1];
      tick(1);
      hi += int'(out_edge[1]);
    end
    check("sat_pulses", 64'(hi), 64'd299);
    check("sat_cnt", 64'(cnt_of(1)), 64'd255);
    repeat (10) begin d[1] = ~d[1]; tick(1); end
    tick(3);
    check("sat_hold", 64'(cnt_of(1)), 64'd255);

    // Clear wins over a simultaneous edge on channel 2
    mode = 2'b01;
    clr = 1'b1; tick(1); clr = 1'b0;
    repeat (7) begin
      d[2] = 1'b1; tick(3);
      d[2] = 1'b0; tick(3);
    end
    check("clr_pre", 64'(cnt_of(2)), 64'd7);
    d[2] = 1'b1;
    tick(1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("clr_edge", 64'(out_edge[2]), 64'h1);
    check("clr_wins", 64'(cnt_of(2)), 64'd0);
    d[2] = 1'b0; tick(3);
    d[2] = 1'b1; tick(3);
    check("clr_after", 64'(cnt_of(2)), 64'd1);

    // Enable gating on channel 3
    mode = 2'b11;
    tick(3);
    en = 1'b0;
    c3 = cnt_of(3);
    ep = 0;
    repeat (4) begin
      d[3] = ~d[3];
      tick(2);
      ep += int'(out_edge[3]);
      check("en_q_follow", 64'(out_q[3]), 64'(d[3]));
      tick(1);
      ep += int'(out_edge[3]);
    end
    check("en_no_pulse", 64'(ep), 64'h0);
    check("en_cnt_hold", 64'(cnt_of(3)), 64'(c3));
    en = 1'b1;
    d[3] = ~d[3];
    tick(3);
    check("en_cnt_inc", 64'(cnt_of(3)), 64'(c3 + 8'd1));

    // Mode 00 then mid-run reset
    mode = 2'b00;
    ep = 0;
    repeat (20) begin
      d = CH'($urandom);
      tick(1);
      ep += int'(out_any);
    end
    check("mode0_pulses", 64'(ep), 64'h0);
    rst_n = 1'b0;
    tick(1);
    check("midrst_all", 64'({out_q, out_edge, out_cnt, out_any}), 64'h0);
    rst_n = 1'b1;

    // Randomised run checked by the model every cycle
    mode = 2'b11;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 2) == 0) d = CH'($urandom);
      en    = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 19) == 0) mode = 2'($urandom);
      clr   = ($urandom_range(0, 49) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
      tick(1);
    end
    rst_n = 1'b1; clr = 1'b0;
    tick(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
